// File: rtl/operand_loader_pkg.sv
// Shared types and constants for the operand loader: FSM state encoding and default widths.
package operand_loader_pkg;

    localparam int STATE_W       = 2;
    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [STATE_W-1:0] {
        S_WAIT_X  = 2'b00,
        S_WAIT_Y  = 2'b01,
        S_READY   = 2'b10,
        S_INVALID = 2'b11
    } state_t;

endpackage

// File: rtl/btn_conditioner.sv
// Raw pushbutton to one-cycle press pulse: 2-flop synchroniser, optional debounce, rising edge.
// Debounce is compiled in with OPERAND_LOADER_DEBOUNCE_EN.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_press
);

    logic [1:0] r_sync;
    logic       r_prev;
    logic       w_level;

    // Everything resets to "pressed" so a button held through reset yields no press.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_raw};
        end
    end

`ifdef OPERAND_LOADER_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_level;

    // Level flips only after DEBOUNCE_CYCLES consecutive mismatching samples.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_level <= 1'b1;
        end else if (r_sync[1] == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_level <= r_sync[1];
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_level = r_level;
`else
    assign w_level = r_sync[1];
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= w_level;
        end
    end

    assign o_press = w_level & ~r_prev;

endmodule

// File: rtl/operand_loader.sv
// Captures X then Y from the switches on successive button presses and presents a stable pair.
// Optional button debounce is selected with OPERAND_LOADER_DEBOUNCE_EN.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int WIDTH           = DEFAULT_WIDTH,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [WIDTH-1:0]   i_sw,
    input  logic               i_btn_load,
    input  logic               i_clear,
    output logic [WIDTH-1:0]   o_x_out,
    output logic [WIDTH-1:0]   o_y_out,
    output logic               o_pair_valid,
    output logic               o_pair_strobe,
    output logic [STATE_W-1:0] o_state_out
);

    logic             w_press;
    state_t           r_state, w_state_d;
    logic [WIDTH-1:0] r_x, w_x_d;
    logic [WIDTH-1:0] r_y, w_y_d;
    logic             r_valid, w_valid_d;
    logic             r_strobe, w_strobe_d;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_conditioner (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_raw  (i_btn_load),
        .o_press(w_press)
    );

    always_comb begin
        w_state_d  = r_state;
        w_x_d      = r_x;
        w_y_d      = r_y;
        w_strobe_d = 1'b0;
        if (i_clear) begin
            w_state_d = S_WAIT_X;
            w_x_d     = '0;
            w_y_d     = '0;
        end else begin
            unique case (r_state)
                S_WAIT_X: begin
                    if (w_press) begin
                        w_x_d     = i_sw;
                        w_state_d = S_WAIT_Y;
                    end
                end
                S_WAIT_Y: begin
                    if (w_press) begin
                        w_y_d      = i_sw;
                        w_strobe_d = 1'b1;
                        w_state_d  = S_READY;
                    end
                end
                S_READY: begin
                    if (w_press) begin
                        w_x_d     = i_sw;
                        w_state_d = S_WAIT_Y;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean empty state.
                    w_state_d = S_WAIT_X;
                    w_x_d     = '0;
                    w_y_d     = '0;
                end
            endcase
        end
        w_valid_d = (w_state_d == S_READY);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= S_WAIT_X;
            r_x      <= '0;
            r_y      <= '0;
            r_valid  <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_x      <= w_x_d;
            r_y      <= w_y_d;
            r_valid  <= w_valid_d;
            r_strobe <= w_strobe_d;
        end
    end

    assign o_x_out       = r_x;
    assign o_y_out       = r_y;
    assign o_pair_valid  = r_valid;
    assign o_pair_strobe = r_strobe;
    assign o_state_out   = r_state;

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader; expected captures are queued at each press and
// compared when the DUT outputs change. Debounce scenarios run when OPERAND_LOADER_DEBOUNCE_EN is set.
module tb_operand_loader;
    import operand_loader_pkg::*;

    localparam int DB = 8;
`ifdef OPERAND_LOADER_DEBOUNCE_EN
    localparam int LAT    = 3 + DB;
    localparam int SETTLE = DB + 6;
`else
    localparam int LAT    = 3;
    localparam int SETTLE = 4;
`endif

    typedef struct packed {
        logic [1:0] st;
        logic [3:0] x;
        logic [3:0] y;
        logic       valid;
        logic       strobe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw;
    logic       btn;
    logic       clear;
    logic [3:0] o_x_out;
    logic [3:0] o_y_out;
    logic       o_pair_valid;
    logic       o_pair_strobe;
    logic [1:0] o_state_out;

    exp_t       sb_q[$];
    logic [1:0] m_state;
    logic [3:0] m_x;
    logic [3:0] m_y;
    int         n_checks = 0;
    int         n_pass   = 0;

    always #5 clk = ~clk;

    operand_loader #(
        .WIDTH          (4),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_sw         (sw),
        .i_btn_load   (btn),
        .i_clear      (clear),
        .o_x_out      (o_x_out),
        .o_y_out      (o_y_out),
        .o_pair_valid (o_pair_valid),
        .o_pair_strobe(o_pair_strobe),
        .o_state_out  (o_state_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check_eq({tag, "_state"},  32'(o_state_out),   32'(e.st));
        check_eq({tag, "_x"},      32'(o_x_out),       32'(e.x));
        check_eq({tag, "_y"},      32'(o_y_out),       32'(e.y));
        check_eq({tag, "_valid"},  32'(o_pair_valid),  32'(e.valid));
        check_eq({tag, "_strobe"}, 32'(o_pair_strobe), 32'(e.strobe));
    endtask

    task automatic model_clear();
        m_state = 2'b00;
        m_x     = 4'h0;
        m_y     = 4'h0;
    endtask

    // Drive one press, wait for the outputs to move, then hold and release the button.
    task automatic do_press(input logic [3:0] v, input int hold);
        exp_t       e;
        logic [9:0] snap;
        int         edges;
        bit         seen;
        case (m_state)
            2'b00:   begin m_x = v; m_state = 2'b01; end
            2'b01:   begin m_y = v; m_state = 2'b10; end
            default: begin m_x = v; m_state = 2'b01; end
        endcase
        e.st     = m_state;
        e.x      = m_x;
        e.y      = m_y;
        e.valid  = (m_state == 2'b10);
        e.strobe = (m_state == 2'b10);
        sb_q.push_back(e);

        @(negedge clk);
        sw   = v;
        btn  = 1'b1;
        snap = {o_state_out, o_x_out, o_y_out};
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
            if ({o_state_out, o_x_out, o_y_out} !== snap) seen = 1'b1;
        end
        check_eq("latency", 32'(edges), 32'(LAT));
        e = sb_q.pop_front();
        check_outputs("capture", e);
        @(posedge clk);
        #1;
        check_eq("strobe_fall", 32'(o_pair_strobe), 32'd0);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        btn = 1'b0;
        repeat (SETTLE) @(posedge clk);
        #1;
        check_eq("no_recapture", 32'({o_state_out, o_x_out, o_y_out}), 32'({e.st, e.x, e.y}));
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        exp_t zero_e;
        zero_e = '0;
        rst_n = 1'b0;
        btn   = 1'b0;
        clear = 1'b0;
        sw    = 4'h0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset", zero_e);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (SETTLE) @(posedge clk);
        #1;
        check_outputs("idle", zero_e);

`ifdef OPERAND_LOADER_DEBOUNCE_EN
        // Short pulses and toggling glitches must never reach the FSM.
        for (int p = 0; p < 3; p++) begin
            @(negedge clk);
            sw  = 4'hF;
            btn = 1'b1;
            repeat (5) @(negedge clk);
            btn = 1'b0;
            repeat (6) @(negedge clk);
        end
        for (int t = 0; t < 16; t++) begin
            @(negedge clk);
            btn = ~btn;
        end
        @(negedge clk);
        btn = 1'b0;
        repeat (SETTLE) @(posedge clk);
        #1;
        check_outputs("glitch", zero_e);
        do_press(4'h6, 1);
        do_press(4'h1, 1);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_clear();
`endif

        do_press(4'h3, 0);
        do_press(4'hA, 0);
        @(posedge clk);
        #1;
        check_eq("ready_hold_valid", 32'(o_pair_valid), 32'd1);
        do_press(4'h7, 0);

        // Clear lands on the same edge as the press in S_WAIT_Y; the press is dropped.
        @(negedge clk);
        sw  = 4'hB;
        btn = 1'b1;
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        model_clear();
        check_outputs("clear", zero_e);
        @(negedge clk);
        clear = 1'b0;
        repeat (LAT + 4) @(posedge clk);
        #1;
        check_outputs("clear_after", zero_e);
        @(negedge clk);
        btn = 1'b0;
        repeat (SETTLE) @(posedge clk);

        do_press(4'h5, 17);

        // Reset mid-sequence with the button held: no capture until release and re-press.
        @(negedge clk);
        sw  = 4'hE;
        btn = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        repeat (2 * LAT + 5) @(posedge clk);
        #1;
        check_outputs("rst_held", zero_e);
        @(negedge clk);
        btn = 1'b0;
        repeat (SETTLE) @(posedge clk);
        do_press(4'h9, 0);
        do_press(4'hC, 0);

        // Illegal state recovers to a cleared S_WAIT_X on the next edge.
        @(negedge clk);
        force dut.r_state = S_INVALID;
        #1;
        release dut.r_state;
        check_eq("forced_state", 32'(o_state_out), 32'd3);
        @(posedge clk);
        #1;
        model_clear();
        check_outputs("recover", zero_e);

        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
